// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the 32-bit team float format
// Holds field widths, the default exponent bias, the conversion status
// codes and the state encoding of the float_to_int FSM.
package fp_pkg;
   localparam int SIGN_W = 1;
   localparam int EXP_W  = 6;
   localparam int MAN_W  = 25;
   localparam int BIAS   = 31;
   localparam logic [3:0] EXACT     = 4'd0;
   localparam logic [3:0] OVERFLOW  = 4'd1;
   localparam logic [3:0] UNDERFLOW = 4'd2;
   localparam logic [3:0] INEXACT   = 4'd3;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      SHIFT  = 3'd2,
      FINISH = 3'd3
   } state_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational field split and classification of a team float
// Ports:
//   op       - float operand {sign, exponent, mantissa}
//   sign     - sign bit
//   man      - 25-bit mantissa (without the implicit 1)
//   u        - unbiased exponent e-BIAS, two's complement
//   n        - shift count |u-25| that aligns 1.m to an integer
//   is_zero  - e=0 and m=0
//   is_under - nonzero operand with magnitude below 1
//   is_over  - magnitude not representable in a signed 32-bit integer
module fp_unpack #(
   parameter int BIAS = 31
) (
   input  logic [31:0] op,
   output logic        sign,
   output logic [24:0] man,
   output logic [7:0]  u,
   output logic [5:0]  n,
   output logic        is_zero,
   output logic        is_under,
   output logic        is_over
);
   import fp_pkg::*;
   logic [EXP_W-1:0]  e;
   logic signed [7:0] us;
   logic signed [7:0] d;
   assign sign     = op[MAN_W+EXP_W +: SIGN_W];
   assign e        = op[MAN_W +: EXP_W];
   assign man      = op[MAN_W-1:0];
   assign us       = signed'(8'({2'b00, e}) - 8'(BIAS));
   assign d        = us - 8'sd25;
   assign u        = us;
   assign n        = d[7] ? 6'(-d) : 6'(d);
   assign is_zero  = (e == '0) && (man == '0);
   assign is_under = !is_zero && us[7];
   // -2^31 is the one magnitude of 2^31 that still fits, hence the sign/mantissa test at u=31
   assign is_over  = (us > 8'sd31) || ((us == 8'sd31) && (!sign || (man != '0)));
endmodule

// File: rtl/float_to_int.sv
// float_to_int: multi-cycle team-float to signed 32-bit integer converter
// Ports:
//   clock_100kHz - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   start        - conversion request, honoured only in IDLE
//   op_in        - float operand, captured with start
//   busy         - conversion in progress
//   done         - one-cycle pulse, data_out/status_out valid
//   data_out     - truncated signed integer result
//   status_out   - EXACT / OVERFLOW / UNDERFLOW / INEXACT
//   qual_lugar   - current FSM state code
module float_to_int #(
   parameter int BIAS = 31
) (
   input  logic        clock_100kHz,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] op_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_out,
   output logic [3:0]  status_out,
   output logic [2:0]  qual_lugar
);
   import fp_pkg::*;
   state_t      state_q, state_d;
   logic [31:0] op_q, op_d, work_q, work_d, data_q, data_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [3:0]  status_q, status_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic        sticky_q, sticky_d, right_q, right_d;
   logic        sign, is_zero, is_under, is_over;
   logic [24:0] man;
   logic [7:0]  u;
   logic [5:0]  n;

   // op_q is held for the whole conversion, so the classification stays valid through FINISH
   fp_unpack #(.BIAS(BIAS)) u_unpack (
      .op       (op_q),
      .sign     (sign),
      .man      (man),
      .u        (u),
      .n        (n),
      .is_zero  (is_zero),
      .is_under (is_under),
      .is_over  (is_over)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sticky_d = sticky_q;
      right_d  = right_q;
      case (state_q)
         IDLE: begin
            op_d    = start ? op_in : op_q;
            busy_d  = start;
            state_d = start ? UNPACK : IDLE;
         end
         UNPACK: begin
            work_d   = {6'b0, 1'b1, man};
            cnt_d    = n;
            right_d  = signed'(u) < 8'sd25;
            sticky_d = 1'b0;
            state_d  = (n != '0 && !(is_zero || is_under || is_over)) ? SHIFT : FINISH;
         end
         SHIFT: begin
            work_d   = right_q ? work_q >> 1 : work_q << 1;
            sticky_d = sticky_q | (right_q & work_q[0]);
            cnt_d    = cnt_q - 6'd1;
            state_d  = (cnt_q == 6'd1) ? FINISH : SHIFT;
         end
         FINISH: begin
            data_d   = is_over ? (sign ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                       (is_under || is_zero) ? 32'h0 :
                       sign ? -work_q : work_q;
            status_d = is_over ? OVERFLOW : is_under ? UNDERFLOW : sticky_q ? INEXACT : EXACT;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_100kHz or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         work_q   <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         status_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sticky_q <= 1'b0;
         right_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sticky_q <= sticky_d;
         right_q  <= right_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign data_out   = data_q;
   assign status_out = status_q;
   assign qual_lugar = state_q;
endmodule
